// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: pipeline port A, long-latency port B (valid/ready),
// regfile write port and the busy mask exported to the hazard unit.
interface wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                   a_valid;
    logic [ADDR_W-1:0]      a_rd;
    logic [DATA_W-1:0]      a_data;
    logic                   a_stall;
    logic                   b_valid;
    logic                   b_ready;
    logic [ADDR_W-1:0]      b_rd;
    logic [DATA_W-1:0]      b_data;
    logic                   RegWrite;
    logic [ADDR_W-1:0]      WriteReg;
    logic [DATA_W-1:0]      WriteData;
    logic [2**ADDR_W-1:0]   busy_mask;

    // Driven by the producers (pipeline, long-latency units) and the regfile side.
    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        input  a_stall, b_ready, RegWrite, WriteReg, WriteData, busy_mask
    );

    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        output a_stall, b_ready, RegWrite, WriteReg, WriteData, busy_mask
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle results (A) with FIFO-buffered long-op
// results (B) onto a registered regfile write port, with starvation guard and WAW kill.
module wb_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int DEPTH     = 2,
    parameter int MAX_STALL = 4
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int SW   = $clog2(MAX_STALL + 1);
    localparam int NREG = 2**ADDR_W;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);

    logic [ADDR_W-1:0] rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  live_q,    live_d;
    logic [PW-1:0]     wr_ptr_q,  wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q,  rd_ptr_d;
    logic [CW-1:0]     count_q,   count_d;
    logic [SW-1:0]     starve_q,  starve_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] wreg_q,    wreg_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [NREG-1:0]   busy;

    logic empty, full, a_stall, a_win, pop, push, a_kill;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == FULL_CNT);
        a_stall = (starve_q == STALL_MAX) && !empty;
        a_win   = bus.a_valid && !a_stall;
        pop     = !a_win && !empty;
        // rd==0 transfers are handshaken but never occupy a slot
        push    = bus.b_valid && !full && (bus.b_rd != '0);
        a_kill  = a_win && (bus.a_rd != '0);
    end

    always_comb begin
        live_d = live_q;
        if (a_kill) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_q[i] == bus.a_rd) live_d[i] = 1'b0;
            end
        end
        if (pop)  live_d[rd_ptr_q] = 1'b0;
        // Applied last so an entry pushed alongside an A win survives the kill
        if (push) live_d[wr_ptr_q] = 1'b1;

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        if (pop || empty)
            starve_d = '0;
        else if (a_win && (starve_q != STALL_MAX))
            starve_d = starve_q + SW'(1);
        else
            starve_d = starve_q;
    end

    always_comb begin
        regwrite_d = 1'b0;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        if (a_win) begin
            regwrite_d = (bus.a_rd != '0);
            wreg_d     = bus.a_rd;
            wdata_d    = bus.a_data;
        end else if (pop) begin
            regwrite_d = live_q[rd_ptr_q];
            wreg_d     = rd_q[rd_ptr_q];
            wdata_d    = data_q[rd_ptr_q];
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) busy[rd_q[i]] = 1'b1;
        end
        busy[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
        end else begin
            live_q     <= live_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
        end
    end

    // Slot payload needs no reset: liveness and occupancy gate every use
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wr_ptr_q]   <= bus.b_rd;
            data_q[wr_ptr_q] <= bus.b_data;
        end
    end

    assign bus.a_stall   = a_stall;
    assign bus.b_ready   = !full;
    assign bus.RegWrite  = regwrite_q;
    assign bus.WriteReg  = wreg_q;
    assign bus.WriteData = wdata_q;
    assign bus.busy_mask = busy;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: per-cycle vector table with a scoreboard of expected
// registered outputs, plus a hand-written asynchronous-reset sequence.
module tb_wb_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(2), .MAX_STALL(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  brd;
        logic [31:0] bd;
        logic        ex_stall;
        logic        ex_bready;
        logic        ex_we;
        logic [4:0]  ex_wr;
        logic [31:0] ex_wd;
        logic [31:0] ex_mask;
    } vec_t;

    typedef struct {
        int          idx;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [31:0] mask;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [31:0] m(input int r);
        return 32'd1 << r;
    endfunction

    function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                                input logic st, input logic br, input logic we,
                                input logic [4:0] wr, input logic [31:0] wd, input logic [31:0] mask);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad; v.bv = bv; v.brd = brd; v.bd = bd;
        v.ex_stall = st; v.ex_bready = br; v.ex_we = we; v.ex_wr = wr; v.ex_wd = wd;
        v.ex_mask = mask;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic bv, input logic [4:0] brd, input logic [31:0] bd);
        bus.a_valid = av; bus.a_rd = ard; bus.a_data = ad;
        bus.b_valid = bv; bus.b_rd = brd; bus.b_data = bd;
    endtask

    initial begin
        exp_t e;

        // av ard ad | bv brd bd | stall bready | we wr wd mask (after the edge)
        // A single write, 1-cycle latency
        vt.push_back(mk(1, 5, 32'hA5A5_0001, 0, 0, 0,          0, 1, 1, 5, 32'hA5A5_0001, 0));
        // Fill both slots under A traffic, then drain 7 then 8; full refuses rd=10
        vt.push_back(mk(1, 1, 32'h11,        1, 7, 32'h1234,   0, 1, 1, 1, 32'h11, m(7)));
        vt.push_back(mk(1, 2, 32'h22,        1, 8, 32'h5678,   0, 1, 1, 2, 32'h22, m(7)|m(8)));
        vt.push_back(mk(0, 0, 0,             1, 10, 32'hAAAA,  0, 0, 1, 7, 32'h1234, m(8)));
        vt.push_back(mk(0, 0, 0,             0, 0, 0,          0, 1, 1, 8, 32'h5678, 0));
        vt.push_back(mk(0, 0, 0,             0, 0, 0,          0, 1, 0, 8, 32'h5678, 0));
        // Starvation: four A wins, then A stalled and rd=3 drained
        vt.push_back(mk(0, 0, 0,             1, 3, 32'h3333,   0, 1, 0, 8, 32'h5678, m(3)));
        vt.push_back(mk(1, 4, 32'h40,        0, 0, 0,          0, 1, 1, 4, 32'h40, m(3)));
        vt.push_back(mk(1, 4, 32'h41,        0, 0, 0,          0, 1, 1, 4, 32'h41, m(3)));
        vt.push_back(mk(1, 4, 32'h42,        0, 0, 0,          0, 1, 1, 4, 32'h42, m(3)));
        vt.push_back(mk(1, 4, 32'h43,        0, 0, 0,          0, 1, 1, 4, 32'h43, m(3)));
        vt.push_back(mk(1, 4, 32'h44,        0, 0, 0,          1, 1, 1, 3, 32'h3333, 0));
        vt.push_back(mk(1, 4, 32'h44,        0, 0, 0,          0, 1, 1, 4, 32'h44, 0));
        // WAW kill: A to rd=9 kills the queued rd=9, which then pops silently
        vt.push_back(mk(0, 0, 0,             1, 9, 32'h9999,   0, 1, 0, 4, 32'h44, m(9)));
        vt.push_back(mk(1, 9, 32'hAAAA_0009, 0, 0, 0,          0, 1, 1, 9, 32'hAAAA_0009, 0));
        vt.push_back(mk(0, 0, 0,             0, 0, 0,          0, 1, 0, 9, 32'h9999, 0));
        vt.push_back(mk(0, 0, 0,             0, 0, 0,          0, 1, 0, 9, 32'h9999, 0));
        // Register 0 on both ports never writes
        vt.push_back(mk(0, 0, 0,             1, 0, 32'hBEEF,   0, 1, 0, 9, 32'h9999, 0));
        vt.push_back(mk(1, 0, 32'hC0C0,      0, 0, 0,          0, 1, 0, 0, 32'hC0C0, 0));
        vt.push_back(mk(0, 0, 0,             0, 0, 0,          0, 1, 0, 0, 32'hC0C0, 0));
        // Kill and push to the same rd in one cycle: only the older entry dies
        vt.push_back(mk(0, 0, 0,             1, 6, 32'h6666,   0, 1, 0, 0, 32'hC0C0, m(6)));
        vt.push_back(mk(1, 6, 32'hA006,      1, 6, 32'h6667,   0, 1, 1, 6, 32'hA006, m(6)));
        vt.push_back(mk(0, 0, 0,             0, 0, 0,          0, 0, 0, 6, 32'h6666, m(6)));
        vt.push_back(mk(0, 0, 0,             0, 0, 0,          0, 1, 1, 6, 32'h6667, 0));
        vt.push_back(mk(0, 0, 0,             0, 0, 0,          0, 1, 0, 6, 32'h6667, 0));

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #7;
        chk("rst.RegWrite",  32'(bus.RegWrite),  32'd0);
        chk("rst.WriteReg",  32'(bus.WriteReg),  32'd0);
        chk("rst.WriteData", bus.WriteData,      32'd0);
        chk("rst.b_ready",   32'(bus.b_ready),   32'd1);
        chk("rst.a_stall",   32'(bus.a_stall),   32'd0);
        chk("rst.busy_mask", bus.busy_mask,      32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vt[i]) begin
            @(negedge clk);
            drive(vt[i].av, vt[i].ard, vt[i].ad, vt[i].bv, vt[i].brd, vt[i].bd);
            #1;
            chk($sformatf("v%0d.a_stall", i), 32'(bus.a_stall), 32'(vt[i].ex_stall));
            chk($sformatf("v%0d.b_ready", i), 32'(bus.b_ready), 32'(vt[i].ex_bready));
            sb.push_back('{idx: i, we: vt[i].ex_we, wr: vt[i].ex_wr, wd: vt[i].ex_wd,
                           mask: vt[i].ex_mask});
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d.RegWrite", e.idx),  32'(bus.RegWrite), 32'(e.we));
                chk($sformatf("v%0d.WriteReg", e.idx),  32'(bus.WriteReg), 32'(e.wr));
                chk($sformatf("v%0d.WriteData", e.idx), bus.WriteData,     e.wd);
                chk($sformatf("v%0d.busy_mask", e.idx), bus.busy_mask,     e.mask);
            end
        end

        // Asynchronous reset mid-cycle with two live entries queued
        @(negedge clk);
        drive(1, 1, 32'h1, 1, 12, 32'h12);
        @(negedge clk);
        drive(1, 2, 32'h2, 1, 13, 32'h13);
        @(posedge clk);
        #1;
        chk("pre_rst.busy_mask", bus.busy_mask,    m(12) | m(13));
        chk("pre_rst.b_ready",   32'(bus.b_ready), 32'd0);
        chk("pre_rst.RegWrite",  32'(bus.RegWrite), 32'd1);
        #2;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("arst.RegWrite",  32'(bus.RegWrite),  32'd0);
        chk("arst.b_ready",   32'(bus.b_ready),   32'd1);
        chk("arst.busy_mask", bus.busy_mask,      32'd0);
        chk("arst.WriteReg",  32'(bus.WriteReg),  32'd0);
        chk("arst.WriteData", bus.WriteData,      32'd0);
        chk("arst.a_stall",   32'(bus.a_stall),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst%0d.RegWrite", k),  32'(bus.RegWrite), 32'd0);
            chk($sformatf("post_rst%0d.busy_mask", k), bus.busy_mask,     32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
